// File: rtl/sync_cdc_tx.sv
// rtl/sync_cdc_tx.sv - write-side source for the valid-tagged CDC bus: ready/valid in, FIFO, throttle, idle gap
// Optional SYNC_CDC_TX_STATS_EN adds tx_count/stall_count saturating counters.
module sync_cdc_tx #(
    parameter int WIDTH = 193,
    parameter int DEPTH = 8,
    parameter int GAP   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-2:0]         s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     throttle,
    output logic [WIDTH-1:0]         data_wr_out,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef SYNC_CDC_TX_STATS_EN
    ,
    output logic [15:0]              tx_count,
    output logic [15:0]              stall_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-2:0]   mem_q [DEPTH];

    logic full;
    logic push;
    logic pop;

    assign full    = (level_q == LW'(DEPTH));
    assign push    = s_valid & ~full;
    assign pop     = (state_q == ST_IDLE) & (level_q != '0) & ~throttle;
    assign s_ready = ~full;

    assign data_wr_out = data_q;
    assign fifo_level  = level_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        data_d    = '0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            data_d   = {1'b1, mem_q[rd_ptr_q]};
        end

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // Gap length is fixed by GAP; throttle neither extends nor shortens it.
        case (state_q)
            ST_IDLE: begin
                if (pop && (GAP > 0)) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GW'(GAP - 1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            data_q    <= data_d;
        end
    end

    // Storage needs no reset: entries are only read once level covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

`ifdef SYNC_CDC_TX_STATS_EN
    logic [15:0] tx_q, tx_d;
    logic [15:0] stall_q, stall_d;
    logic        stall_inc;

    assign stall_inc = (level_q != '0) & throttle & (state_q == ST_IDLE);

    always_comb begin
        tx_d    = tx_q;
        stall_d = stall_q;
        if (pop && (tx_q != 16'hFFFF)) begin
            tx_d = tx_q + 16'd1;
        end
        if (stall_inc && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q    <= '0;
            stall_q <= '0;
        end else begin
            tx_q    <= tx_d;
            stall_q <= stall_d;
        end
    end

    assign tx_count    = tx_q;
    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_sync_cdc_tx.sv
// tb/tb_sync_cdc_tx.sv - directed self-checking bench for sync_cdc_tx (GAP=0 and GAP=2 instances)
module tb_sync_cdc_tx;

    localparam int W = 17;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [W-2:0] a_data, b_data;
    logic         a_valid, b_valid, a_thr, b_thr;
    logic         a_ready, b_ready;
    logic [W-1:0] a_out, b_out;
    logic [3:0]   a_lvl, b_lvl;
`ifdef SYNC_CDC_TX_STATS_EN
    logic [15:0]  a_tx, a_stall, b_tx, b_stall;
`endif

    sync_cdc_tx #(.WIDTH(W), .DEPTH(D), .GAP(0)) u_a (
        .clk(clk), .rst(rst), .s_data(a_data), .s_valid(a_valid), .s_ready(a_ready),
        .throttle(a_thr), .data_wr_out(a_out), .fifo_level(a_lvl)
`ifdef SYNC_CDC_TX_STATS_EN
        , .tx_count(a_tx), .stall_count(a_stall)
`endif
    );

    sync_cdc_tx #(.WIDTH(W), .DEPTH(D), .GAP(2)) u_b (
        .clk(clk), .rst(rst), .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
        .throttle(b_thr), .data_wr_out(b_out), .fifo_level(b_lvl)
`ifdef SYNC_CDC_TX_STATS_EN
        , .tx_count(b_tx), .stall_count(b_stall)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] sb[$];
    int pushed, emitted, acc, peak;
    logic [31:0] exp_w;

    initial begin
        a_data = '0; a_valid = 1'b0; a_thr = 1'b0;
        b_data = '0; b_valid = 1'b0; b_thr = 1'b0;

        #12;
        chk("rst_out", 32'(a_out), 32'h0);
        chk("rst_lvl", 32'(a_lvl), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("rst_ready", 32'(a_ready), 32'h1);
        chk("rst_out_b", 32'(b_out), 32'h0);

        // basic back-to-back, GAP=0
        a_valid = 1'b1; a_data = 16'h1;
        step();
        chk("basic_e1_out", 32'(a_out), 32'h0);
        chk("basic_e1_lvl", 32'(a_lvl), 32'h1);
        a_data = 16'h2;
        step();
        chk("basic_w1", 32'(a_out), 32'h10001);
        a_data = 16'h3;
        step();
        chk("basic_w2", 32'(a_out), 32'h10002);
        a_valid = 1'b0;
        step();
        chk("basic_w3", 32'(a_out), 32'h10003);
        chk("basic_lvl0", 32'(a_lvl), 32'h0);
        step();
        chk("basic_idle", 32'(a_out), 32'h0);

        // GAP=2: each word followed by two zero cycles
        peak = 0;
        b_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i < 4) b_data = 16'hA1 + 16'(i);
            else       b_valid = 1'b0;
            step();
            exp_w = 32'h0;
            if (i % 3 == 1) exp_w = 32'h10000 | (32'hA1 + 32'(i / 3));
            chk("gap_seq", 32'(b_out), exp_w);
            if (int'(b_lvl) > peak) peak = int'(b_lvl);
        end
        chk("gap_peak", 32'(peak), 32'h3);
        chk("gap_drained", 32'(b_lvl), 32'h0);

        // throttle fills FIFO to DEPTH
        a_thr = 1'b1; acc = 0;
        for (int i = 0; i < 10; i++) begin
            a_valid = 1'b1;
            a_data = 16'h20 + 16'(i);
            if (a_ready) acc++;
            step();
            chk("thr_out0", 32'(a_out), 32'h0);
        end
        chk("thr_accepted", 32'(acc), 32'h8);
        chk("thr_full_ready", 32'(a_ready), 32'h0);
        chk("thr_full_lvl", 32'(a_lvl), 32'h8);
        a_valid = 1'b0; a_thr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("thr_drain", 32'(a_out), 32'h10020 + 32'(i));
            if (i == 0) chk("thr_ready_back", 32'(a_ready), 32'h1);
        end
        step();
        chk("thr_end_out", 32'(a_out), 32'h0);
        chk("thr_end_lvl", 32'(a_lvl), 32'h0);

        // simultaneous push/pop at level 4 across pointer wrap
        pushed = 0; emitted = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            a_valid = (pushed < 3 * D);
            a_data = 16'h100 + 16'(pushed);
            a_thr = (pushed < 4);
            if (a_valid && a_ready) begin
                sb.push_back(a_data);
                pushed++;
            end
            step();
            if (a_out[W-1]) begin
                if (sb.size() == 0) begin
                    chk("wrap_underflow", 32'h1, 32'h0);
                end else begin
                    chk("wrap_data", 32'(a_out[W-2:0]), 32'(sb.pop_front()));
                    emitted++;
                end
            end
            if (cyc >= 3 && cyc <= 23) chk("wrap_lvl4", 32'(a_lvl), 32'h4);
        end
        chk("wrap_emitted", 32'(emitted), 32'(3 * D));
        chk("wrap_sb_empty", 32'(sb.size()), 32'h0);
        chk("wrap_lvl_end", 32'(a_lvl), 32'h0);
        a_valid = 1'b0; a_thr = 1'b0;

        // asynchronous reset mid-stream
        a_thr = 1'b1; a_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_data = 16'h300 + 16'(i);
            step();
        end
        a_valid = 1'b0; a_thr = 1'b0;
        step();
        chk("mrst_pre_out", 32'(a_out), 32'h10300);
        chk("mrst_pre_lvl", 32'(a_lvl), 32'h5);
        #2 rst = 1'b1;
        #1;
        chk("mrst_out", 32'(a_out), 32'h0);
        chk("mrst_lvl", 32'(a_lvl), 32'h0);
        chk("mrst_ready", 32'(a_ready), 32'h1);
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mrst_no_stale", 32'(a_out), 32'h0);
        end
        chk("mrst_lvl_after", 32'(a_lvl), 32'h0);

`ifdef SYNC_CDC_TX_STATS_EN
        // two stall edges while pushing (level already nonzero), then 20 more
        a_thr = 1'b1; a_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_data = 16'h400 + 16'(i);
            step();
        end
        a_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("stats_stall", 32'(a_stall), 32'd22);
        chk("stats_tx0", 32'(a_tx), 32'd0);
        a_thr = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("stats_tx3", 32'(a_tx), 32'd3);
        chk("stats_stall_hold", 32'(a_stall), 32'd22);
        a_valid = 1'b1; a_data = 16'h555;
        for (int i = 0; i < 70000; i++) step();
        chk("stats_tx_sat", 32'(a_tx), 32'h0000FFFF);
        a_valid = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
